// File: rtl/addr8s_share_ctrl_pkg.sv
// Shared types and constants for the time-shared 8-bit signed adder controller.
//   OPW   : operand width of the shared adder.
//   SUMW  : adder result width (one guard bit, no truncation).
//   ERRW  : width of the saturating mismatch counter.
//   state_t : controller FSM states.
package addr8s_ctrl_pkg;

  localparam int OPW  = 8;
  localparam int SUMW = 9;
  localparam int ERRW = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    PASS2 = 3'd2,
    CHECK = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/addr8s_share_ctrl_if.sv
// Bus bundle between the requesters / shared adder and the controller.
//   req_valid/req_ready/req_a/req_b : per-requester request channel (slice i = requester i).
//   add_a/add_b/add_sum             : operands to and result from the external adder.
//   rsp_*                           : single response channel back to the requesters.
//   err_cnt                         : saturating count of redundancy mismatches.
// Modports: slave = controller view, master = requester/adder environment view.
interface addr8s_share_ctrl_if
  import addr8s_ctrl_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic [OPW-1:0]      add_a;
  logic [OPW-1:0]      add_b;
  logic [SUMW-1:0]     add_sum;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [SUMW-1:0]     rsp_sum;
  logic                rsp_err;
  logic [ERRW-1:0]     err_cnt;

  modport slave (
    input  req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_err, err_cnt
  );

  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_err, err_cnt
  );

endinterface

// File: rtl/addr8s_share_ctrl_arb.sv
// Round-robin arbiter: grants the first requester at or after i_ptr, wrapping.
//   i_req : request vector      i_ptr : highest-priority index
//   i_en  : grant enable        o_gnt : one-hot grant   o_idx : encoded grant index
module addr8s_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx
);

  always_comb begin
    int   j;
    logic found;
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (i_en && !found && i_req[j]) begin
        found    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/addr8s_share_ctrl.sv
// Time-shares one external 8-bit signed adder among NREQ requesters with
// round-robin arbitration and temporal redundancy (A+B then B+A, compared).
// A mismatch retries up to MAX_RETRY times, then responds with rsp_err set.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/adder/response bundle (controller side)
module addr8s_share_ctrl
  import addr8s_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 2,
  parameter int REDUNDANT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addr8s_share_ctrl_if.slave   bus
);

  localparam int         IDW   = $clog2(NREQ);
  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t            r_state, w_next;
  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_idx;
  logic              w_any;
  logic              w_match;
  logic [IDW-1:0]    r_ptr, r_id;
  logic [OPW-1:0]    r_a, r_b;
  logic [SUMW-1:0]   r_sum1, r_sum2, r_rsp_sum;
  logic              r_rsp_err;
  logic [2:0]        r_retry;
  logic [ERRW-1:0]   r_err_cnt;

  addr8s_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .i_en  (r_state == IDLE),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_any   = |w_gnt;
  assign w_match = (r_sum1 == r_sum2);

  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.err_cnt   = r_err_cnt;

  // Next state, accept pulse and adder operands. Operands stay 0 outside the
  // two compute passes so the shared adder does not toggle needlessly.
  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          bus.req_ready = w_gnt;
          w_next        = PASS1;
        end
      end
      PASS1: begin
        bus.add_a = r_a;
        bus.add_b = r_b;
        w_next    = (REDUNDANT != 0) ? PASS2 : RESP;
      end
      PASS2: begin
        bus.add_a = r_b;
        bus.add_b = r_a;
        w_next    = CHECK;
      end
      CHECK: begin
        if (!w_match && (r_retry < MAX_R)) w_next = PASS1;
        else                               w_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand/result datapath and counters. The data registers are reset as
  // well because they drive the response outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sum1    <= '0;
      r_sum2    <= '0;
      r_rsp_sum <= '0;
      r_rsp_err <= 1'b0;
      r_retry   <= '0;
      r_err_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= bus.req_a[int'(w_idx)*OPW +: OPW];
            r_b     <= bus.req_b[int'(w_idx)*OPW +: OPW];
            r_id    <= w_idx;
            r_retry <= '0;
          end
        end
        PASS1: begin
          r_sum1 <= bus.add_sum;
          if (REDUNDANT == 0) begin
            r_rsp_sum <= bus.add_sum;
            r_rsp_err <= 1'b0;
          end
        end
        PASS2: r_sum2 <= bus.add_sum;
        CHECK: begin
          if (w_match) begin
            r_rsp_sum <= r_sum1;
            r_rsp_err <= 1'b0;
          end else begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERRW'(1);
            if (r_retry < MAX_R) begin
              r_retry <= r_retry + 3'd1;
            end else begin
              r_rsp_sum <= r_sum1;
              r_rsp_err <= 1'b1;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addr8s_share_ctrl.sv
// Self-checking bench for addr8s_share_ctrl: behavioural adder with fault
// injection in PASS2, scoreboard of expected responses filled at accept time.
module tb_addr8s_share_ctrl;
  import addr8s_ctrl_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addr8s_share_ctrl_if #(.NREQ(NREQ)) bus ();

  addr8s_share_ctrl #(.NREQ(NREQ), .MAX_RETRY(2), .REDUNDANT(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] add9(input logic [7:0] a, input logic [7:0] b);
    return {a[7], a} + {b[7], b};
  endfunction

  // Adder model. A fault flips sum bit 3 whenever the swapped operand pair
  // (f_b, f_a) is presented, until fault_limit corruptions have happened.
  logic [7:0] f_a = 8'h55, f_b = 8'hAA;
  int fault_limit = 0, fault_used = 0;
  logic w_fault;
  assign w_fault     = (bus.add_a == f_b) && (bus.add_b == f_a) && (fault_used < fault_limit);
  assign bus.add_sum = add9(bus.add_a, bus.add_b) ^ (w_fault ? 9'h008 : 9'h000);
  always @(posedge clk) if (w_fault) fault_used <= fault_used + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [8:0] sum;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  logic exp_err = 1'b0;
  int   exp_lat = 4;
  bit   prev_valid = 1'b0;

  // Monitor: pushes expectations on accept, checks latency and response contents.
  always @(negedge clk) begin
    int   g;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_valid = 1'b0;
    end else begin
      if (bus.req_ready != '0) begin
        check("ready_onehot", $countones(bus.req_ready), 1);
        g = 0;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        check("ready_has_valid", bus.req_valid[g], 1);
        e.id  = g;
        e.sum = add9(bus.req_a[g*8 +: 8], bus.req_b[g*8 +: 8]);
        e.err = exp_err;
        e.lat = exp_lat;
        e.acc = cyc;
        sb.push_back(e);
        grant_log.push_back(g);
      end
      if (bus.rsp_valid && !prev_valid) begin
        if (sb.size() == 0) check("rsp_unexpected", bus.rsp_valid, 0);
        else                check("rsp_latency", cyc - sb[0].acc, sb[0].lat);
      end
      if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("rsp_id",  bus.rsp_id,  e.id);
        check("rsp_sum", bus.rsp_sum, e.sum);
        check("rsp_err", bus.rsp_err, e.err);
      end
      prev_valid = bus.rsp_valid;
    end
  end

  task automatic drive(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
    bus.req_valid[i]    = 1'b1;
  endtask

  // Waits for requester i to be accepted, then drops its valid after the edge.
  task automatic wait_accept(input int i);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[i] && t < 100);
    check("accept", bus.req_ready[i], 1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    drive(i, a, b);
    wait_accept(i);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic check_quiet(input string p);
    check({p, "_rsp_valid"}, bus.rsp_valid, 0);
    check({p, "_req_ready"}, bus.req_ready, 0);
    check({p, "_add_a"},     bus.add_a,     0);
    check({p, "_add_b"},     bus.add_b,     0);
    check({p, "_rsp_sum"},   bus.rsp_sum,   0);
    check({p, "_rsp_err"},   bus.rsp_err,   0);
    check({p, "_rsp_id"},    bus.rsp_id,    0);
    check({p, "_err_cnt"},   bus.err_cnt,   0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t;
    int any_rsp;
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    // Basic sums, rsp_ready already high before rsp_valid.
    send(0, 8'h7F, 8'h7F); drain();
    send(2, 8'h80, 8'h80); drain();
    send(1, 8'h05, 8'hFB); drain();

    // All requesters valid continuously: strict rotation from pointer 0.
    do_reset();
    grant_log.delete();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) drive(i, 8'(i*37 + 3), 8'(8'hF0 - i));
    t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (grant_log.size() < 6 && t < 300);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain();
    check("grant_count", grant_log.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < grant_log.size()) check($sformatf("grant_%0d", k), grant_log[k], exp_order[k]);

    // Single transient PASS2 fault: one retry, three cycles later, no error flag.
    f_a = 8'h03; f_b = 8'h11;
    fault_limit = fault_used + 1;
    exp_lat = 7;
    send(3, 8'h03, 8'h11); drain();
    exp_lat = 4;
    check("err_cnt_once", bus.err_cnt, 1);

    // Persistent PASS2 fault: all retries fail, response carries PASS1 sum.
    do_reset();
    f_a = 8'h01; f_b = 8'h02;
    fault_limit = fault_used + 100;
    exp_err = 1'b1;
    exp_lat = 10;
    send(0, 8'h01, 8'h02); drain();
    exp_err = 1'b0;
    exp_lat = 4;
    fault_limit = fault_used;
    check("err_cnt_stuck", bus.err_cnt, 3);

    // Reset during PASS2: operation dropped, no response afterwards.
    send(1, 8'h20, 8'h30);
    @(negedge clk);
    check("pass1_add_a", bus.add_a, 8'h20);
    check("pass1_add_b", bus.add_b, 8'h30);
    @(negedge clk);
    check("pass2_add_a", bus.add_a, 8'h30);
    check("pass2_add_b", bus.add_b, 8'h20);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("mid_reset");
    rst_n = 1'b1;
    any_rsp = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) any_rsp++;
    end
    check("no_rsp_after_reset", any_rsp, 0);
    check_quiet("after_mid_reset");

    // Response stall with another requester waiting.
    bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    drive(1, 8'h11, 8'h22);
    drive(0, 8'h9C, 8'hC8);
    wait_accept(0);
    t = 0;
    while (!bus.rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (5) begin
      @(negedge clk);
      check("stall_rsp_valid", bus.rsp_valid, 1);
      check("stall_rsp_sum",   bus.rsp_sum,   9'h164);
      check("stall_rsp_id",    bus.rsp_id,    0);
      check("stall_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    wait_accept(1);
    drain();
    check("idle_add_a", bus.add_a, 0);
    check("idle_add_b", bus.add_b, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
